// File: rtl/instr_buffer_pkg.sv
// Shared widths and helpers for the fetch-to-decode instruction buffer.
// The widths mirror the header constants used elsewhere in the CPU.
package instr_buffer_pkg;

  localparam int IB_DEPTH    = 16;
  localparam int PTAB_ADDR_W = 4;
  localparam int FOUR_WORD_W = 128;
  localparam int INST_W      = 32;
  localparam int PC_W        = 32;
  localparam int LANES       = 4;

  // Number of words a fetch packet carries, given the slot of its first valid word.
  function automatic logic [2:0] packet_words(input logic [1:0] first_slot);
    return 3'd4 - {1'b0, first_slot};
  endfunction

endpackage

// File: rtl/instr_buffer_queue_mem.sv
// DEPTH-entry instruction storage: one 4-lane masked write port, two asynchronous read ports.
// Lane j of a write lands at entry (wr_base + j) modulo DEPTH.
module ib_queue_mem
  import instr_buffer_pkg::*;
#(
  parameter int DEPTH  = IB_DEPTH,
  parameter int PTAB_W = PTAB_ADDR_W,
  parameter int AW     = $clog2(IB_DEPTH)
) (
  input  logic                      clk,
  input  logic [AW-1:0]             wr_base,
  input  logic [LANES-1:0]          wr_mask,
  input  logic [LANES*INST_W-1:0]   wr_inst,
  input  logic [LANES*PC_W-1:0]     wr_pc,
  input  logic [PTAB_W-1:0]         wr_ptab,
  input  logic [PC_W-1:0]           wr_branch_pc,
  input  logic [LANES-1:0]          wr_delot,
  input  logic [AW-1:0]             rd_addr0,
  input  logic [AW-1:0]             rd_addr1,
  output logic [INST_W-1:0]         rd_inst0,
  output logic [PC_W-1:0]           rd_pc0,
  output logic [PTAB_W-1:0]         rd_ptab0,
  output logic [PC_W-1:0]           rd_branch_pc0,
  output logic                      rd_delot0,
  output logic [INST_W-1:0]         rd_inst1,
  output logic [PC_W-1:0]           rd_pc1,
  output logic [PTAB_W-1:0]         rd_ptab1,
  output logic [PC_W-1:0]           rd_branch_pc1,
  output logic                      rd_delot1
);

  logic [INST_W-1:0] inst_mem      [DEPTH];
  logic [PC_W-1:0]   pc_mem        [DEPTH];
  logic [PTAB_W-1:0] ptab_mem      [DEPTH];
  logic [PC_W-1:0]   branch_pc_mem [DEPTH];
  logic              delot_mem     [DEPTH];

  logic [INST_W-1:0] lane_inst [LANES];
  logic [PC_W-1:0]   lane_pc   [LANES];
  logic [AW-1:0]     lane_addr [LANES];

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_inst[gi] = wr_inst[gi*INST_W +: INST_W];
      assign lane_pc[gi]   = wr_pc[gi*PC_W +: PC_W];
      // Pointer arithmetic wraps naturally at AW bits, which keeps wrap-around writes contiguous.
      assign lane_addr[gi] = wr_base + AW'(gi);
    end
  endgenerate

  // Lanes always target distinct entries, so the loop order never matters.
  always_ff @(posedge clk) begin
    for (int j = 0; j < LANES; j++) begin
      if (wr_mask[j]) begin
        inst_mem[lane_addr[j]]      <= lane_inst[j];
        pc_mem[lane_addr[j]]        <= lane_pc[j];
        ptab_mem[lane_addr[j]]      <= wr_ptab;
        branch_pc_mem[lane_addr[j]] <= wr_branch_pc;
        delot_mem[lane_addr[j]]     <= wr_delot[j];
      end
    end
  end

  assign rd_inst0      = inst_mem[rd_addr0];
  assign rd_pc0        = pc_mem[rd_addr0];
  assign rd_ptab0      = ptab_mem[rd_addr0];
  assign rd_branch_pc0 = branch_pc_mem[rd_addr0];
  assign rd_delot0     = delot_mem[rd_addr0];

  assign rd_inst1      = inst_mem[rd_addr1];
  assign rd_pc1        = pc_mem[rd_addr1];
  assign rd_ptab1      = ptab_mem[rd_addr1];
  assign rd_branch_pc1 = branch_pc_mem[rd_addr1];
  assign rd_delot1     = delot_mem[rd_addr1];

endmodule

// File: rtl/instr_buffer.sv
// Circular instruction buffer: up to 4 words in per cycle from the I-cache, up to 2 out
// per cycle to decode, with ib_allin throttling fetch whenever fewer than 4 entries are free.
module instr_buffer
  import instr_buffer_pkg::*;
#(
  parameter int DEPTH  = IB_DEPTH,
  parameter int PTAB_W = PTAB_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   icache_ib_valid,
  input  logic [FOUR_WORD_W-1:0] icache_ib_data,
  input  logic [PC_W-1:0]        icache_ib_pc,
  input  logic [PTAB_W-1:0]      icache_ib_ptab,
  input  logic [PC_W-1:0]        icache_ib_branch_pc,
  input  logic                   icache_ib_delot_en,
  output logic                   ib_allin,
  input  logic                   id_ready,
  output logic                   ib_id_valid0,
  output logic                   ib_id_valid1,
  output logic [INST_W-1:0]      ib_id_inst0,
  output logic [INST_W-1:0]      ib_id_inst1,
  output logic [PC_W-1:0]        ib_id_pc0,
  output logic [PC_W-1:0]        ib_id_pc1,
  output logic [PTAB_W-1:0]      ib_id_ptab0,
  output logic [PTAB_W-1:0]      ib_id_ptab1,
  output logic [PC_W-1:0]        ib_id_branch_pc0,
  output logic [PC_W-1:0]        ib_id_branch_pc1,
  output logic                   ib_id_delot0,
  output logic                   ib_id_delot1
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] head_reg, head_next;
  logic [AW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;

  logic          wr_fire;
  logic          rd_fire;
  logic [1:0]    first_slot;
  logic [2:0]    wr_n;
  logic [2:0]    wr_n_eff;
  logic [1:0]    rd_n;

  logic [LANES-1:0]        wr_mask;
  logic [LANES*INST_W-1:0] wr_inst;
  logic [LANES*PC_W-1:0]   wr_pc;
  logic [LANES-1:0]        wr_delot;

  logic [INST_W-1:0] mem_inst0, mem_inst1;
  logic [PC_W-1:0]   mem_pc0, mem_pc1;
  logic [PTAB_W-1:0] mem_ptab0, mem_ptab1;
  logic [PC_W-1:0]   mem_branch_pc0, mem_branch_pc1;
  logic              mem_delot0, mem_delot1;

  // Back-pressure looks only at the registered count, so fetch never sees an input-to-output path.
  assign ib_allin     = count_reg <= CW'(DEPTH - 4);
  assign ib_id_valid0 = count_reg >= CW'(1);
  assign ib_id_valid1 = count_reg >= CW'(2);

  assign first_slot = icache_ib_pc[3:2];
  assign wr_n       = packet_words(first_slot);
  assign wr_fire    = icache_ib_valid & ib_allin & ~flush;
  assign rd_fire    = id_ready & ~flush;
  assign wr_n_eff   = wr_fire ? wr_n : 3'd0;
  assign rd_n       = rd_fire ? ({1'b0, ib_id_valid0} + {1'b0, ib_id_valid1}) : 2'd0;

  // Lane j carries packet slot first_slot+j; lanes past the end of the packet are masked off.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_wr_lane
      logic [1:0] lane_slot;
      assign lane_slot                   = first_slot + 2'(gi);
      assign wr_mask[gi]                 = wr_fire & (3'(gi) < wr_n);
      assign wr_inst[gi*INST_W +: INST_W] = icache_ib_data[lane_slot*INST_W +: INST_W];
      assign wr_pc[gi*PC_W +: PC_W]       = {icache_ib_pc[PC_W-1:4], lane_slot, 2'b00};
      if (gi == 0) begin : g_first
        assign wr_delot[gi] = icache_ib_delot_en;
      end else begin : g_rest
        assign wr_delot[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    head_next  = head_reg + AW'(rd_n);
    tail_next  = tail_reg + AW'(wr_n_eff);
    count_next = count_reg + CW'(wr_n_eff) - CW'(rd_n);
    if (reset || flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    head_reg  <= head_next;
    tail_reg  <= tail_next;
    count_reg <= count_next;
  end

  ib_queue_mem #(
    .DEPTH  (DEPTH),
    .PTAB_W (PTAB_W),
    .AW     (AW)
  ) u_mem (
    .clk           (clk),
    .wr_base       (tail_reg),
    .wr_mask       (wr_mask),
    .wr_inst       (wr_inst),
    .wr_pc         (wr_pc),
    .wr_ptab       (icache_ib_ptab),
    .wr_branch_pc  (icache_ib_branch_pc),
    .wr_delot      (wr_delot),
    .rd_addr0      (head_reg),
    .rd_addr1      (head_reg + AW'(1)),
    .rd_inst0      (mem_inst0),
    .rd_pc0        (mem_pc0),
    .rd_ptab0      (mem_ptab0),
    .rd_branch_pc0 (mem_branch_pc0),
    .rd_delot0     (mem_delot0),
    .rd_inst1      (mem_inst1),
    .rd_pc1        (mem_pc1),
    .rd_ptab1      (mem_ptab1),
    .rd_branch_pc1 (mem_branch_pc1),
    .rd_delot1     (mem_delot1)
  );

  // Unoccupied issue slots present zeros so decode never sees stale storage.
  assign ib_id_inst0      = ib_id_valid0 ? mem_inst0      : '0;
  assign ib_id_pc0        = ib_id_valid0 ? mem_pc0        : '0;
  assign ib_id_ptab0      = ib_id_valid0 ? mem_ptab0      : '0;
  assign ib_id_branch_pc0 = ib_id_valid0 ? mem_branch_pc0 : '0;
  assign ib_id_delot0     = ib_id_valid0 & mem_delot0;

  assign ib_id_inst1      = ib_id_valid1 ? mem_inst1      : '0;
  assign ib_id_pc1        = ib_id_valid1 ? mem_pc1        : '0;
  assign ib_id_ptab1      = ib_id_valid1 ? mem_ptab1      : '0;
  assign ib_id_branch_pc1 = ib_id_valid1 ? mem_branch_pc1 : '0;
  assign ib_id_delot1     = ib_id_valid1 & mem_delot1;

endmodule

// File: tb/tb_instr_buffer.sv
// Scoreboard bench for instr_buffer: a queue model of the buffer is updated at each clock
// edge and a negedge monitor compares every issue slot and ib_allin against it.
module tb_instr_buffer;

  localparam int DEPTH  = 16;
  localparam int PTAB_W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         icache_ib_valid;
  logic [127:0] icache_ib_data;
  logic [31:0]  icache_ib_pc;
  logic [PTAB_W-1:0] icache_ib_ptab;
  logic [31:0]  icache_ib_branch_pc;
  logic         icache_ib_delot_en;
  logic         ib_allin;
  logic         id_ready;
  logic         ib_id_valid0, ib_id_valid1;
  logic [31:0]  ib_id_inst0, ib_id_inst1;
  logic [31:0]  ib_id_pc0, ib_id_pc1;
  logic [PTAB_W-1:0] ib_id_ptab0, ib_id_ptab1;
  logic [31:0]  ib_id_branch_pc0, ib_id_branch_pc1;
  logic         ib_id_delot0, ib_id_delot1;

  instr_buffer #(.DEPTH(DEPTH), .PTAB_W(PTAB_W)) dut (
    .clk                 (clk),
    .reset               (reset),
    .flush               (flush),
    .icache_ib_valid     (icache_ib_valid),
    .icache_ib_data      (icache_ib_data),
    .icache_ib_pc        (icache_ib_pc),
    .icache_ib_ptab      (icache_ib_ptab),
    .icache_ib_branch_pc (icache_ib_branch_pc),
    .icache_ib_delot_en  (icache_ib_delot_en),
    .ib_allin            (ib_allin),
    .id_ready            (id_ready),
    .ib_id_valid0        (ib_id_valid0),
    .ib_id_valid1        (ib_id_valid1),
    .ib_id_inst0         (ib_id_inst0),
    .ib_id_inst1         (ib_id_inst1),
    .ib_id_pc0           (ib_id_pc0),
    .ib_id_pc1           (ib_id_pc1),
    .ib_id_ptab0         (ib_id_ptab0),
    .ib_id_ptab1         (ib_id_ptab1),
    .ib_id_branch_pc0    (ib_id_branch_pc0),
    .ib_id_branch_pc1    (ib_id_branch_pc1),
    .ib_id_delot0        (ib_id_delot0),
    .ib_id_delot1        (ib_id_delot1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]       inst;
    logic [31:0]       pc;
    logic [PTAB_W-1:0] ptab;
    logic [31:0]       bpc;
    logic              delot;
  } entry_t;

  entry_t exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: the buffer is just a FIFO of instruction records.
  always @(posedge clk) begin
    int n;
    int first;
    entry_t e;
    if (reset || flush) begin
      exp_q.delete();
    end else begin
      n = exp_q.size();
      if (id_ready)
        repeat ((n > 2) ? 2 : n) void'(exp_q.pop_front());
      if (icache_ib_valid && (DEPTH - n) >= 4) begin
        first = int'(icache_ib_pc[3:2]);
        for (int s = first; s < 4; s++) begin
          e.inst  = icache_ib_data[32*s +: 32];
          e.pc    = {icache_ib_pc[31:4], 4'b0000} + 32'(4 * s);
          e.ptab  = icache_ib_ptab;
          e.bpc   = icache_ib_branch_pc;
          e.delot = (s == first) && icache_ib_delot_en;
          exp_q.push_back(e);
        end
      end
    end
  end

  // Monitor: compare the presented issue slots against the head of the model queue.
  always @(negedge clk) begin
    int n;
    n = exp_q.size();
    check("valid0", 64'(ib_id_valid0), 64'(n >= 1));
    check("valid1", 64'(ib_id_valid1), 64'(n >= 2));
    check("allin",  64'(ib_allin),     64'((DEPTH - n) >= 4));
    if (n >= 1) begin
      check("inst0",  64'(ib_id_inst0),      64'(exp_q[0].inst));
      check("pc0",    64'(ib_id_pc0),        64'(exp_q[0].pc));
      check("ptab0",  64'(ib_id_ptab0),      64'(exp_q[0].ptab));
      check("bpc0",   64'(ib_id_branch_pc0), 64'(exp_q[0].bpc));
      check("delot0", 64'(ib_id_delot0),     64'(exp_q[0].delot));
    end else begin
      check("slot0_zero", {ib_id_inst0, ib_id_pc0} | 64'(ib_id_branch_pc0)
                          | 64'(ib_id_ptab0) | 64'(ib_id_delot0), 64'd0);
    end
    if (n >= 2) begin
      check("inst1",  64'(ib_id_inst1),      64'(exp_q[1].inst));
      check("pc1",    64'(ib_id_pc1),        64'(exp_q[1].pc));
      check("ptab1",  64'(ib_id_ptab1),      64'(exp_q[1].ptab));
      check("bpc1",   64'(ib_id_branch_pc1), 64'(exp_q[1].bpc));
      check("delot1", 64'(ib_id_delot1),     64'(exp_q[1].delot));
    end else begin
      check("slot1_zero", {ib_id_inst1, ib_id_pc1} | 64'(ib_id_branch_pc1)
                          | 64'(ib_id_ptab1) | 64'(ib_id_delot1), 64'd0);
    end
  end

  logic [127:0] last_data;
  logic [127:0] saved_data;

  // Drive one cycle of stimulus; returns just after the following negedge.
  task automatic send(input logic v, input logic [31:0] pc, input logic dl,
                      input logic rdy, input logic fl);
    icache_ib_valid     = v;
    icache_ib_pc        = pc;
    icache_ib_data      = {$urandom, $urandom, $urandom, $urandom};
    icache_ib_ptab      = PTAB_W'($urandom);
    icache_ib_branch_pc = $urandom;
    icache_ib_delot_en  = dl;
    id_ready            = rdy;
    flush               = fl;
    last_data           = icache_ib_data;
    @(negedge clk);
    #1;
  endtask

  initial begin
    int rdy_pct;
    reset = 1'b1;
    send(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    send(1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
    send(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    check("reset_valid0", 64'(ib_id_valid0), 64'd0);
    check("reset_allin", 64'(ib_allin), 64'd1);

    // Aligned packets fill the buffer.
    send(1'b1, 32'h1000, 1'b0, 1'b0, 1'b0);
    check("al_inst0", 64'(ib_id_inst0), 64'(last_data[31:0]));
    check("al_pc0", 64'(ib_id_pc0), 64'h1000);
    check("al_inst1", 64'(ib_id_inst1), 64'(last_data[63:32]));
    check("al_pc1", 64'(ib_id_pc1), 64'h1004);
    send(1'b1, 32'h1010, 1'b0, 1'b0, 1'b0);
    send(1'b1, 32'h1020, 1'b0, 1'b0, 1'b0);
    send(1'b1, 32'h1030, 1'b0, 1'b0, 1'b0);
    check("full_allin", 64'(ib_allin), 64'd0);
    check("full_valid1", 64'(ib_id_valid1), 64'd1);

    // Packet while full is dropped.
    send(1'b1, 32'h6000, 1'b0, 1'b0, 1'b0);
    check("drop_pc0", 64'(ib_id_pc0), 64'h1000);
    check("drop_allin", 64'(ib_allin), 64'd0);

    // Flush while full with a valid packet presented.
    send(1'b1, 32'h7000, 1'b0, 1'b1, 1'b1);
    check("flush_valid0", 64'(ib_id_valid0), 64'd0);
    check("flush_valid1", 64'(ib_id_valid1), 64'd0);
    check("flush_allin", 64'(ib_allin), 64'd1);
    send(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("flush_nostore", 64'(ib_id_valid0), 64'd0);

    // Unaligned packet with a delay slot.
    send(1'b1, 32'h2008, 1'b1, 1'b0, 1'b0);
    check("ua_pc0", 64'(ib_id_pc0), 64'h2008);
    check("ua_inst0", 64'(ib_id_inst0), 64'(last_data[95:64]));
    check("ua_delot0", 64'(ib_id_delot0), 64'd1);
    check("ua_pc1", 64'(ib_id_pc1), 64'h200C);
    check("ua_delot1", 64'(ib_id_delot1), 64'd0);

    // Simultaneous read and write from count 5.
    send(1'b1, 32'h3004, 1'b0, 1'b0, 1'b0);
    send(1'b1, 32'h3010, 1'b0, 1'b1, 1'b0);
    check("rw_pc0", 64'(ib_id_pc0), 64'h3004);
    check("rw_pc1", 64'(ib_id_pc1), 64'h3008);

    // Wrap-around: park head and tail at 14, then write a full packet.
    send(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    send(1'b1, 32'h4000, 1'b0, 1'b0, 1'b0);
    send(1'b1, 32'h4010, 1'b0, 1'b0, 1'b0);
    send(1'b1, 32'h4020, 1'b0, 1'b0, 1'b0);
    send(1'b1, 32'h4038, 1'b0, 1'b0, 1'b0);
    repeat (7) send(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("wrap_empty", 64'(ib_id_valid0), 64'd0);
    send(1'b1, 32'h5000, 1'b0, 1'b0, 1'b0);
    saved_data = last_data;
    check("wrap_pc0", 64'(ib_id_pc0), 64'h5000);
    check("wrap_pc1", 64'(ib_id_pc1), 64'h5004);
    send(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("wrap_pc2", 64'(ib_id_pc0), 64'h5008);
    check("wrap_inst2", 64'(ib_id_inst0), 64'(saved_data[95:64]));
    check("wrap_pc3", 64'(ib_id_pc1), 64'h500C);
    check("wrap_inst3", 64'(ib_id_inst1), 64'(saved_data[127:96]));

    // Reset mid-stream dominates a concurrent write and read.
    reset = 1'b1;
    send(1'b1, 32'h8000, 1'b1, 1'b1, 1'b1);
    reset = 1'b0;
    check("rst_valid0", 64'(ib_id_valid0), 64'd0);
    check("rst_inst0", 64'(ib_id_inst0), 64'd0);
    check("rst_pc0", 64'(ib_id_pc0), 64'd0);
    check("rst_allin", 64'(ib_allin), 64'd1);

    // Randomized traffic, alternating between fill-heavy and drain-heavy phases.
    for (int i = 0; i < 3000; i++) begin
      rdy_pct = ((i / 400) % 2 == 0) ? 25 : 80;
      reset = ($urandom_range(0, 299) == 0);
      send($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 0,
           $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 49) == 0);
    end
    reset = 1'b0;
    send(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
